mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- MEM pipeline stage of the MIPS datapath. Sits between the EX/MEM boundary and the word-addressed `data_memory`.
- Converts byte addresses to word indices and checks alignment and range.
- Performs byte/halfword stores as a two-cycle read-modify-write with pipeline stall.
- Extracts and extends sub-word load data, then registers results into the MEM/WB boundary.

Parameters:
- DEPTH, 64, number of 32-bit words in `data_memory`; a word index >= DEPTH is a range fault.
- ADDR_W, 32, byte-address width from the ALU.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset, synchronous, active-low
- ex_valid  in  1  EX/MEM holds a valid instruction
- ex_mem_read  in  1  load request
- ex_mem_write  in  1  store request
- ex_size  in  2  00 byte, 01 half, 10 word; 11 illegal
- ex_unsigned  in  1  zero-extend loads (lbu/lhu)
- ex_addr  in  32  byte address (ALU result)
- ex_store_data  in  32  rt value; low bits are used for sub-word stores
- ex_rd  in  5  destination register
- ex_reg_write  in  1  instruction writes the register file
- dm_read  out  1  drives `data_memory` memRead
- dm_write  out  1  drives `data_memory` memWrite
- dm_address  out  32  word index = {2'b00, ex_addr[31:2]}
- dm_write_data  out  32  full word to store
- dm_read_data  in  32  `data_memory` read_data (combinational)
- stall  out  1  hold IF/ID/EX; EX/MEM inputs must stay stable while high
- wb_valid  out  1  MEM/WB valid
- wb_reg_write  out  1  MEM/WB register-write enable
- wb_rd  out  5  MEM/WB destination
- wb_data  out  32  load data, or ex_addr passthrough for non-memory instructions
- fault  out  1  one-cycle pulse: misaligned, out-of-range, illegal size, or read+write both set

Behaviour:
- **Reset:** rst sampled low at a clock edge gives:
  - state IDLE;
  - wb_valid, wb_reg_write, wb_rd, wb_data, fault = 0;
  - merge register = 0.
  - Combinational outputs dm_read, dm_write and stall are 0 while rst is low.
- **Byte order:** little-endian. Lane n = ex_addr[1:0] occupies bits 8n+7:8n. Halfword lane = ex_addr[1].
- **Fault conditions:**
  - half with ex_addr[0]=1;
  - word with ex_addr[1:0]!=0;
  - word index >= DEPTH;
  - ex_size=11;
  - ex_mem_read and ex_mem_write both set.
- **Fault response:** no dm_read/dm_write. Next cycle: wb_valid=1, wb_reg_write=0, fault=1 for that one cycle.
- **State IDLE:**
  - Non-memory valid instruction: next edge registers wb_data=ex_addr and wb_reg_write=ex_reg_write.
  - Load: dm_read=1 in the same cycle. Aligned/extended data is captured into wb_data at the next edge, so latency = 1 cycle. No stall.
  - Word store: dm_write=1 and dm_write_data=ex_store_data for exactly this one cycle. wb_reg_write=0 next cycle.
  - Byte/half store: dm_read=1 and stall=1; latch merged word (dm_read_data with lane(s) replaced by ex_store_data[7:0] or [15:0]); go to RMW_WR. No WB update this edge (wb_valid=0).
- **State RMW_WR:**
  - dm_write=1, dm_write_data=merge register, dm_read=0, stall=0.
  - Next edge: wb_valid=1, wb_reg_write=0; return to IDLE.
- **Invalid slots:** ex_valid=0 gives no memory access and wb_valid=0 next cycle.
- **Glitch-free write:** dm_write is never high in two consecutive cycles for the same store. dm_write_data and dm_address are stable throughout any cycle in which dm_write is high.
- **Reset mid-RMW:** abort; the memory write is never issued.
- **Back-to-back:** an instruction following an RMW store is accepted in the cycle after RMW_WR. A load to the just-written word returns the merged value.

Decomposition:
- Package `mips_mem_pkg`:
  - SIZE_BYTE/SIZE_HALF/SIZE_WORD codes;
  - FSM state encodings IDLE/RMW_WR;
  - DEPTH default.
- Sub-module `mem_lane_align` (combinational):
  - load extract + sign/zero extend;
  - store lane merge.

Test Plan:
- Memory word index 1 = 0x8899AABB; lw addr 4 -> wb_data=0x8899AABB one cycle later, stall never high.
- lb addr 5 -> wb_data=0xFFFFFFAA; lbu addr 5 -> 0x000000AA; lh addr 6 -> 0xFFFF8899; lhu addr 6 -> 0x00008899.
- sb data 0x12345677 to addr 6 -> stall high 1 cycle; dm_write single cycle with 0x8877AABB at index 1; subsequent lw addr 4 returns 0x8877AABB.
- Misaligned: lh addr 7 and sw addr 2; out of range: lw addr 256 (index 64) -> fault pulse, dm_read=dm_write=0, wb_reg_write=0.
- sh 0xBEEF to addr 4 with rst driven low during RMW_WR -> no dm_write, memory word unchanged; all outputs 0 after that edge.
- Alternating add passthrough / sw / lw stream -> wb_data/wb_rd match expected each cycle with no spurious stalls.

Source files
------------

// File: rtl/mips_mem_pkg.sv
// Shared encodings for the MIPS MEM stage: access sizes, FSM states and memory depth.
package mips_mem_pkg;

  localparam int DEPTH_DEFAULT = 64;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;
  localparam logic [1:0] SIZE_BAD  = 2'b11;

  typedef enum logic {
    IDLE   = 1'b0,
    RMW_WR = 1'b1
  } state_e;

endpackage

// File: rtl/mem_lane_align.sv
// Little-endian lane handling: extracts/extends sub-word load data and merges
// sub-word store data into a full memory word.
module mem_lane_align
  import mips_mem_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] rd_word_i,
  input  logic [31:0] st_data_i,
  output logic [31:0] load_data_o,
  output logic [31:0] merged_o
);

  logic [7:0]  byteSel;
  logic [15:0] halfSel;

  always_comb begin
    byteSel     = rd_word_i[{addr_lo_i, 3'b000} +: 8];
    halfSel     = addr_lo_i[1] ? rd_word_i[31:16] : rd_word_i[15:0];
    load_data_o = rd_word_i;
    merged_o    = st_data_i;
    case (size_i)
      SIZE_BYTE: begin
        load_data_o = unsigned_i ? {24'h000000, byteSel} : {{24{byteSel[7]}}, byteSel};
        merged_o    = rd_word_i;
        merged_o[{addr_lo_i, 3'b000} +: 8] = st_data_i[7:0];
      end
      SIZE_HALF: begin
        load_data_o = unsigned_i ? {16'h0000, halfSel} : {{16{halfSel[15]}}, halfSel};
        merged_o    = rd_word_i;
        if (addr_lo_i[1]) merged_o[31:16] = st_data_i[15:0];
        else              merged_o[15:0]  = st_data_i[15:0];
      end
      default: begin
        load_data_o = rd_word_i;
        merged_o    = st_data_i;
      end
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MIPS MEM stage: address checking, loads, word stores, and two-cycle
// read-modify-write for byte/halfword stores, feeding the MEM/WB register.
module mem_access_unit
  import mips_mem_pkg::*;
#(
  parameter int DEPTH  = DEPTH_DEFAULT,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  input  logic              ex_mem_read,
  input  logic              ex_mem_write,
  input  logic [1:0]        ex_size,
  input  logic              ex_unsigned,
  input  logic [ADDR_W-1:0] ex_addr,
  input  logic [31:0]       ex_store_data,
  input  logic [4:0]        ex_rd,
  input  logic              ex_reg_write,
  output logic              dm_read,
  output logic              dm_write,
  output logic [31:0]       dm_address,
  output logic [31:0]       dm_write_data,
  input  logic [31:0]       dm_read_data,
  output logic              stall,
  output logic              wb_valid,
  output logic              wb_reg_write,
  output logic [4:0]        wb_rd,
  output logic [31:0]       wb_data,
  output logic              fault
);

  localparam int IDX_W = ADDR_W - 2;

  state_e      state_q;
  logic [31:0] merge_q;
  logic        wb_valid_q;
  logic        wb_reg_write_q;
  logic [4:0]  wb_rd_q;
  logic [31:0] wb_data_q;
  logic        fault_q;

  logic [IDX_W-1:0] wordIdx;
  logic [31:0]      loadData;
  logic [31:0]      mergedWord;
  logic isMem, badSize, misaligned, outOfRange, faultC;
  logic doLoad, doWordStore, doSubStore;

  assign wordIdx    = ex_addr[ADDR_W-1:2];
  assign dm_address = 32'(wordIdx);

  mem_lane_align u_align (
    .size_i      (ex_size),
    .unsigned_i  (ex_unsigned),
    .addr_lo_i   (ex_addr[1:0]),
    .rd_word_i   (dm_read_data),
    .st_data_i   (ex_store_data),
    .load_data_o (loadData),
    .merged_o    (mergedWord)
  );

  always_comb begin
    isMem       = ex_mem_read | ex_mem_write;
    badSize     = (ex_size == SIZE_BAD);
    misaligned  = ((ex_size == SIZE_HALF) && ex_addr[0]) ||
                  ((ex_size == SIZE_WORD) && (ex_addr[1:0] != 2'b00));
    outOfRange  = (wordIdx >= IDX_W'(DEPTH));
    faultC      = ex_valid && isMem &&
                  ((ex_mem_read && ex_mem_write) || badSize || misaligned || outOfRange);
    doLoad      = ex_valid && ex_mem_read && !faultC;
    doWordStore = ex_valid && ex_mem_write && !faultC && (ex_size == SIZE_WORD);
    doSubStore  = ex_valid && ex_mem_write && !faultC && (ex_size != SIZE_WORD);
  end

  // Memory strobes are gated by reset so an RMW caught by reset never writes.
  always_comb begin
    dm_read       = 1'b0;
    dm_write      = 1'b0;
    stall         = 1'b0;
    dm_write_data = ex_store_data;
    if (rst) begin
      case (state_q)
        IDLE: begin
          dm_read  = doLoad | doSubStore;
          dm_write = doWordStore;
          stall    = doSubStore;
        end
        RMW_WR: begin
          dm_write      = 1'b1;
          dm_write_data = merge_q;
        end
        default: dm_write = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q        <= IDLE;
      merge_q        <= '0;
      wb_valid_q     <= 1'b0;
      wb_reg_write_q <= 1'b0;
      wb_rd_q        <= '0;
      wb_data_q      <= '0;
      fault_q        <= 1'b0;
    end else begin
      fault_q <= 1'b0;
      case (state_q)
        IDLE: begin
          wb_rd_q        <= ex_rd;
          wb_valid_q     <= ex_valid && !doSubStore;
          wb_reg_write_q <= 1'b0;
          if (faultC) begin
            fault_q <= 1'b1;
          end else if (doSubStore) begin
            merge_q <= mergedWord;
            state_q <= RMW_WR;
          end else if (doLoad) begin
            wb_data_q      <= loadData;
            wb_reg_write_q <= ex_reg_write;
          end else if (ex_valid && !isMem) begin
            wb_data_q      <= 32'(ex_addr);
            wb_reg_write_q <= ex_reg_write;
          end
        end
        RMW_WR: begin
          wb_valid_q     <= 1'b1;
          wb_reg_write_q <= 1'b0;
          wb_rd_q        <= ex_rd;
          state_q        <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign wb_valid     = wb_valid_q;
  assign wb_reg_write = wb_reg_write_q;
  assign wb_rd        = wb_rd_q;
  assign wb_data      = wb_data_q;
  assign fault        = fault_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a behavioural 64-word data memory.
module tb_mem_access_unit;

  logic        clk;
  logic        rst;
  logic        ex_valid, ex_mem_read, ex_mem_write, ex_unsigned, ex_reg_write;
  logic [1:0]  ex_size;
  logic [31:0] ex_addr, ex_store_data;
  logic [4:0]  ex_rd;
  logic        dm_read, dm_write, stall, wb_valid, wb_reg_write, fault;
  logic [31:0] dm_address, dm_write_data, dm_read_data, wb_data;
  logic [4:0]  wb_rd;

  logic [31:0] mem [0:63];
  logic        loadImage;
  logic        prevWrite;
  int          writeCount;
  int          backToBackWrites;
  int          checks;
  int          errors;

  mem_access_unit dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_size(ex_size), .ex_unsigned(ex_unsigned),
    .ex_addr(ex_addr), .ex_store_data(ex_store_data), .ex_rd(ex_rd),
    .ex_reg_write(ex_reg_write), .dm_read(dm_read), .dm_write(dm_write),
    .dm_address(dm_address), .dm_write_data(dm_write_data),
    .dm_read_data(dm_read_data), .stall(stall), .wb_valid(wb_valid),
    .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_data(wb_data), .fault(fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign dm_read_data = (dm_address < 32'd64) ? mem[dm_address[5:0]] : 32'hDEAD_DEAD;

  // Data memory plus write-strobe monitoring (total writes, back-to-back writes).
  always @(posedge clk) begin
    if (loadImage) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'(i) * 32'h0101_0101;
      mem[1]           <= 32'h8899_AABB;
      writeCount       <= 0;
      backToBackWrites <= 0;
      prevWrite        <= 1'b0;
    end else begin
      if (dm_write && dm_address < 32'd64) mem[dm_address[5:0]] <= dm_write_data;
      if (dm_write) writeCount <= writeCount + 1;
      if (dm_write && prevWrite) backToBackWrites <= backToBackWrites + 1;
      prevWrite <= dm_write;
    end
  end

  task automatic applyStimulus(input logic v, input logic r, input logic w,
                               input logic [1:0] sz, input logic u,
                               input logic [31:0] a, input logic [31:0] d,
                               input logic [4:0] rdi, input logic rw);
    ex_valid = v; ex_mem_read = r; ex_mem_write = w; ex_size = sz; ex_unsigned = u;
    ex_addr = a; ex_store_data = d; ex_rd = rdi; ex_reg_write = rw;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    loadImage = 1'b1;
    applyStimulus(1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 32'd4, 32'd0, 5'd1, 1'b1);
    @(posedge clk); #1;
    loadImage = 1'b0;
    @(negedge clk);
    checks++; if (dm_read !== 1'b0) begin errors++; $display("FAIL reset_dm_read got %b exp 0", dm_read); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b exp 0", stall); end
    @(posedge clk); #1;
    checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL reset_wb_valid got %b exp 0", wb_valid); end
    checks++; if (wb_data !== 32'h0) begin errors++; $display("FAIL reset_wb_data got %h exp 0", wb_data); end
    checks++; if (fault !== 1'b0 || wb_reg_write !== 1'b0 || wb_rd !== 5'd0) begin
      errors++; $display("FAIL reset_regs got fault=%b rw=%b rd=%0d exp 0", fault, wb_reg_write, wb_rd);
    end
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 32'd0, 32'd0, 5'd0, 1'b0);
  endtask

  task automatic test_loads;
    logic [31:0] addrs [5] = '{32'd4, 32'd5, 32'd5, 32'd6, 32'd6};
    logic [1:0]  sizes [5] = '{2'b10, 2'b00, 2'b00, 2'b01, 2'b01};
    logic        unsg  [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [31:0] exps  [5] = '{32'h8899_AABB, 32'hFFFF_FFAA, 32'h0000_00AA,
                               32'hFFFF_8899, 32'h0000_8899};
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, sizes[i], unsg[i], addrs[i], 32'd0, 5'(i + 10), 1'b1);
      @(negedge clk);
      checks++; if (dm_read !== 1'b1 || stall !== 1'b0 || dm_address !== 32'd1) begin
        errors++; $display("FAIL load%0d_access got rd=%b stall=%b addr=%h exp 1 0 1", i, dm_read, stall, dm_address);
      end
      @(posedge clk); #1;
      checks++; if (wb_data !== exps[i]) begin errors++; $display("FAIL load%0d_data got %h exp %h", i, wb_data, exps[i]); end
      checks++; if (wb_valid !== 1'b1 || wb_reg_write !== 1'b1 || wb_rd !== 5'(i + 10)) begin
        errors++; $display("FAIL load%0d_wb got v=%b rw=%b rd=%0d exp 1 1 %0d", i, wb_valid, wb_reg_write, wb_rd, i + 10);
      end
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 32'd0, 32'd0, 5'd0, 1'b0);
  endtask

  task automatic test_sub_store;
    int writesBefore;
    writesBefore = writeCount;
    applyStimulus(1'b1, 1'b0, 1'b1, 2'b00, 1'b0, 32'd6, 32'h1234_5677, 5'd0, 1'b0);
    @(negedge clk);
    checks++; if (stall !== 1'b1 || dm_read !== 1'b1 || dm_write !== 1'b0) begin
      errors++; $display("FAIL sb_read_phase got stall=%b rd=%b wr=%b exp 1 1 0", stall, dm_read, dm_write);
    end
    @(posedge clk); #1;
    checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL sb_no_wb got %b exp 0", wb_valid); end
    @(negedge clk);
    checks++; if (dm_write !== 1'b1 || dm_read !== 1'b0 || stall !== 1'b0) begin
      errors++; $display("FAIL sb_write_phase got wr=%b rd=%b stall=%b exp 1 0 0", dm_write, dm_read, stall);
    end
    checks++; if (dm_write_data !== 32'h8877_AABB || dm_address !== 32'd1) begin
      errors++; $display("FAIL sb_merge got %h@%h exp 8877aabb@1", dm_write_data, dm_address);
    end
    @(posedge clk); #1;
    checks++; if (wb_valid !== 1'b1 || wb_reg_write !== 1'b0) begin
      errors++; $display("FAIL sb_wb got v=%b rw=%b exp 1 0", wb_valid, wb_reg_write);
    end
    checks++; if (mem[1] !== 32'h8877_AABB) begin errors++; $display("FAIL sb_mem got %h exp 8877aabb", mem[1]); end
    applyStimulus(1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 32'd4, 32'd0, 5'd9, 1'b1);
    @(negedge clk);
    checks++; if (dm_write !== 1'b0 || stall !== 1'b0) begin
      errors++; $display("FAIL sb_follow_strobes got wr=%b stall=%b exp 0 0", dm_write, stall);
    end
    @(posedge clk); #1;
    checks++; if (wb_data !== 32'h8877_AABB) begin errors++; $display("FAIL sb_readback got %h exp 8877aabb", wb_data); end
    checks++; if (writeCount !== writesBefore + 1) begin
      errors++; $display("FAIL sb_write_count got %0d exp %0d", writeCount, writesBefore + 1);
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 32'd0, 32'd0, 5'd0, 1'b0);
  endtask

  task automatic test_faults;
    logic        rds   [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    logic        wrs   [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [1:0]  sizes [5] = '{2'b01, 2'b10, 2'b10, 2'b11, 2'b10};
    logic [31:0] addrs [5] = '{32'd7, 32'd2, 32'd256, 32'd4, 32'd4};
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, rds[i], wrs[i], sizes[i], 1'b0, addrs[i], 32'hFFFF_FFFF, 5'd4, 1'b1);
      @(negedge clk);
      checks++; if (dm_read !== 1'b0 || dm_write !== 1'b0 || stall !== 1'b0) begin
        errors++; $display("FAIL fault%0d_access got rd=%b wr=%b stall=%b exp 0 0 0", i, dm_read, dm_write, stall);
      end
      @(posedge clk); #1;
      checks++; if (fault !== 1'b1 || wb_valid !== 1'b1 || wb_reg_write !== 1'b0) begin
        errors++; $display("FAIL fault%0d_flag got f=%b v=%b rw=%b exp 1 1 0", i, fault, wb_valid, wb_reg_write);
      end
      applyStimulus(1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 32'd0, 32'd0, 5'd0, 1'b0);
      @(posedge clk); #1;
      checks++; if (fault !== 1'b0 || wb_valid !== 1'b0) begin
        errors++; $display("FAIL fault%0d_pulse got f=%b v=%b exp 0 0", i, fault, wb_valid);
      end
    end
  endtask

  task automatic test_reset_mid_rmw;
    int writesBefore;
    writesBefore = writeCount;
    applyStimulus(1'b1, 1'b0, 1'b1, 2'b01, 1'b0, 32'd4, 32'h0000_BEEF, 5'd0, 1'b0);
    @(negedge clk);
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL rmwrst_stall got %b exp 1", stall); end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++; if (dm_write !== 1'b0) begin errors++; $display("FAIL rmwrst_dm_write got %b exp 0", dm_write); end
    @(posedge clk); #1;
    checks++; if (mem[1] !== 32'h8877_AABB || writeCount !== writesBefore) begin
      errors++; $display("FAIL rmwrst_mem got %h writes=%0d exp 8877aabb %0d", mem[1], writeCount, writesBefore);
    end
    checks++; if (wb_valid !== 1'b0 || fault !== 1'b0 || wb_data !== 32'h0 || wb_rd !== 5'd0 || wb_reg_write !== 1'b0) begin
      errors++; $display("FAIL rmwrst_outputs got v=%b f=%b d=%h rd=%0d rw=%b exp all 0", wb_valid, fault, wb_data, wb_rd, wb_reg_write);
    end
    checks++; if (dm_read !== 1'b0 || dm_write !== 1'b0 || stall !== 1'b0) begin
      errors++; $display("FAIL rmwrst_strobes got rd=%b wr=%b stall=%b exp 0 0 0", dm_read, dm_write, stall);
    end
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 32'd0, 32'd0, 5'd0, 1'b0);
    @(negedge clk);
    checks++; if (dm_write !== 1'b0) begin errors++; $display("FAIL rmwrst_state got wr=%b exp 0", dm_write); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back;
    logic        vs   [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    logic        rs   [7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    logic        ws   [7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [1:0]  szs  [7] = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b00};
    logic        us   [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [31:0] as   [7] = '{32'h0000_1234, 32'd8, 32'd8, 32'hDEAD_BEEC, 32'd12, 32'd4, 32'd11};
    logic [4:0]  rds  [7] = '{5'd3, 5'd0, 5'd5, 5'd7, 5'd2, 5'd6, 5'd8};
    logic        rws  [7] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    logic        expV [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    logic        expR [7] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    logic        chkD [7] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    logic [31:0] expD [7] = '{32'h0000_1234, 32'h0, 32'hCAFE_F00D, 32'hDEAD_BEEC,
                              32'h0, 32'h8877_AABB, 32'h0000_00CA};
    for (int i = 0; i < 7; i++) begin
      applyStimulus(vs[i], rs[i], ws[i], szs[i], us[i], as[i], 32'hCAFE_F00D, rds[i], rws[i]);
      @(negedge clk);
      checks++; if (stall !== 1'b0 || dm_write !== ws[i]) begin
        errors++; $display("FAIL stream%0d_strobes got stall=%b wr=%b exp 0 %b", i, stall, dm_write, ws[i]);
      end
      @(posedge clk); #1;
      checks++; if (wb_valid !== expV[i] || wb_reg_write !== expR[i]) begin
        errors++; $display("FAIL stream%0d_wb got v=%b rw=%b exp %b %b", i, wb_valid, wb_reg_write, expV[i], expR[i]);
      end
      if (expV[i]) begin
        checks++; if (wb_rd !== rds[i]) begin errors++; $display("FAIL stream%0d_rd got %0d exp %0d", i, wb_rd, rds[i]); end
      end
      if (chkD[i]) begin
        checks++; if (wb_data !== expD[i]) begin errors++; $display("FAIL stream%0d_data got %h exp %h", i, wb_data, expD[i]); end
      end
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 32'd0, 32'd0, 5'd0, 1'b0);
    @(posedge clk); #1;
    checks++; if (backToBackWrites !== 0) begin
      errors++; $display("FAIL consecutive_writes got %0d exp 0", backToBackWrites);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_loads();
    test_sub_store();
    test_faults();
    test_reset_mid_rmw();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
